// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: major opcodes, instruction formats and the canonical NOP.
// The decoder imports the same constants, so encode/decode stay consistent.
package rv32i_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_t;

    function automatic fmt_t fmt_of(input logic [4:0] opc);
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: return FMT_I;
            OPC_STORE:                      return FMT_S;
            OPC_BRANCH:                     return FMT_B;
            OPC_OP:                         return FMT_R;
            OPC_LUI, OPC_AUIPC:             return FMT_U;
            OPC_JAL:                        return FMT_J;
            default:                        return FMT_BAD;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_enc_fifo.sv
// Two-entry in-order valid/ready FIFO with registered outputs (no bypass path).
module rv32i_enc_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    // Ready comes from registered occupancy only, so a pop at full does not open the input.
    assign in_ready  = !rst && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/rv32i_encoder.sv
// Streaming RV32I encoder: packs decoded fields into an instruction word, flags
// out-of-range or misaligned immediates, and buffers results in a 2-entry FIFO.
module rv32i_encoder
    import rv32i_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_WORD = NOP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_opcode,
    input  logic [2:0]       in_func3,
    input  logic [6:0]       in_func7,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic             err_seen,
    output logic [CNT_W-1:0] enc_count
);

    fmt_t        fmt;
    logic [31:0] word;
    logic        err;
    logic        is_shift;
    logic        i_ok;
    logic        b_ok;
    logic        j_ok;
    logic [32:0] fifo_out;

    assign fmt      = fmt_of(in_opcode);
    assign is_shift = (in_opcode == OPC_OP_IMM) && (in_func3[1:0] == 2'b01);
    assign i_ok     = (&in_imm[31:11]) || !(|in_imm[31:11]);
    assign b_ok     = (&in_imm[31:12]) || !(|in_imm[31:12]);
    assign j_ok     = (&in_imm[31:20]) || !(|in_imm[31:20]);

    always_comb begin
        word = NOP_WORD;
        err  = 1'b1;
        case (fmt)
            FMT_R: begin
                word = {in_func7, in_rs2, in_rs1, in_func3, in_rd, in_opcode, 2'b11};
                err  = 1'b0;
            end
            FMT_I: begin
                if (is_shift) begin
                    word = {in_func7, in_imm[4:0], in_rs1, in_func3, in_rd, in_opcode, 2'b11};
                    err  = |in_imm[31:5];
                end else begin
                    word = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode, 2'b11};
                    err  = !i_ok;
                end
            end
            FMT_S: begin
                word = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], in_opcode, 2'b11};
                err  = !i_ok;
            end
            FMT_B: begin
                word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                        in_imm[4:1], in_imm[11], in_opcode, 2'b11};
                err  = in_imm[0] || !b_ok;
            end
            FMT_U: begin
                word = {in_imm[31:12], in_rd, in_opcode, 2'b11};
                err  = |in_imm[11:0];
            end
            FMT_J: begin
                word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                        in_rd, in_opcode, 2'b11};
                err  = in_imm[0] || !j_ok;
            end
            default: begin
                word = NOP_WORD;
                err  = 1'b1;
            end
        endcase
    end

    rv32i_enc_fifo #(
        .W(33)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({word, err}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (fifo_out)
    );

    assign out_instr = fifo_out[32:1];
    assign out_err   = fifo_out[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            err_seen  <= 1'b0;
            enc_count <= '0;
        end else if (out_valid && out_ready) begin
            enc_count <= enc_count + 1'b1;
            if (out_err) begin
                err_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_encoder.sv
// Scoreboard bench for rv32i_encoder: the driver queues hand-computed words on
// acceptance, the monitor pops and compares on every output handshake.
module tb_rv32i_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [2:0]  in_func3;
    logic [6:0]  in_func7;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic        err_seen;
    logic [15:0] enc_count;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int valid_cycles = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    rv32i_encoder #(
        .CNT_W   (16),
        .NOP_WORD(32'h0000_0013)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_opcode(in_opcode),
        .in_func3 (in_func3),
        .in_func7 (in_func7),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_rd    (in_rd),
        .in_imm   (in_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_err  (out_err),
        .err_seen (err_seen),
        .enc_count(enc_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sampling on the falling edge keeps the monitor clear of the active edge.
    always @(negedge clk) begin
        if (out_valid) valid_cycles++;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %h/%0d expected none", out_instr, out_err);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({out_instr, out_err} !== e) begin
                    errors++;
                    $display("FAIL word: got %h err %0d expected %h err %0d",
                             out_instr, out_err, e[32:1], e[0]);
                end
            end
        end
    end

    task automatic set_fields(input logic [4:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] imm);
        in_opcode = opc;
        in_func3  = f3;
        in_func7  = f7;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_rd     = rd;
        in_imm    = imm;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [4:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] imm, input logic [31:0] exp_w, input logic exp_e);
        bit done = 0;
        set_fields(opc, f3, f7, rs1, rs2, rd, imm);
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({exp_w, exp_e});
                done = 1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_fields('0, '0, '0, '0, '0, '0, '0);
        idle(3);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_seen", 32'(err_seen), 32'd0);
        chk("rst_enc_count", 32'(enc_count), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Legal encodings; the first also checks single-cycle latency.
        send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 32'h0050_0093, 1'b0);
        @(negedge clk);
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        send(5'b01000, 3'b010, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 32'hFE20_AE23, 1'b0);
        send(5'b11011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd8, 32'h0080_00EF, 1'b0);
        send(5'b01101, 3'b000, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        send(5'b01100, 3'b000, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0020_81B3, 1'b0);
        send(5'b00100, 3'b001, 7'd0, 5'd1, 5'd0, 5'd1, 32'd3, 32'h0030_9093, 1'b0);
        send(5'b00100, 3'b101, 7'h20, 5'd1, 5'd0, 5'd1, 32'd3, 32'h4030_D093, 1'b0);
        send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
        idle(3);
        @(negedge clk);
        chk("no_err_seen_yet", 32'(err_seen), 32'd0);
        chk("count_8", 32'(enc_count), 32'd8);
        @(posedge clk);
        #1;

        // Error encodings.
        send(5'b11000, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3, 32'h0000_0163, 1'b1);
        idle(2);
        @(negedge clk);
        chk("err_seen_after_beq", 32'(err_seen), 32'd1);
        @(posedge clk);
        #1;
        send(5'b01101, 3'b000, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5678, 32'h1234_52B7, 1'b1);
        send(5'b00001, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_0013, 1'b1);
        send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0800, 32'h8000_0093, 1'b1);
        send(5'b00100, 3'b001, 7'd0, 5'd1, 5'd0, 5'd1, 32'd32, 32'h0000_9093, 1'b1);
        idle(3);
        @(negedge clk);
        chk("count_13", 32'(enc_count), 32'd13);
        @(posedge clk);
        #1;

        // Backpressure: two words fill the FIFO, the third is held off.
        out_ready = 1'b0;
        send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd1, 32'h0010_0093, 1'b0);
        send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'd2, 32'd2, 32'h0020_0113, 1'b0);
        set_fields(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'd3, 32'd3);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_instr", out_instr, 32'h0010_0093);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        stalls = 0;
        send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'd3, 32'd3, 32'h0030_0193, 1'b0);
        chk("bp_third_waited", 32'(stalls > 0), 32'd1);
        idle(4);
        @(negedge clk);
        chk("count_16", 32'(enc_count), 32'd16);
        @(posedge clk);
        #1;

        // Streaming with out_ready high: no stalls, one word per cycle.
        stalls = 0;
        valid_cycles = 0;
        for (int i = 1; i <= 10; i++) begin
            send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'(i), 32'(i),
                 (32'(i) << 20) | (32'(i) << 7) | 32'h13, 1'b0);
        end
        idle(3);
        @(negedge clk);
        chk("stream_stalls", 32'(stalls), 32'd0);
        chk("stream_valid_cycles", 32'(valid_cycles), 32'd10);
        chk("count_26", 32'(enc_count), 32'd26);
        @(posedge clk);
        #1;

        // Reset with two entries held.
        out_ready = 1'b0;
        send(5'b00001, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_0013, 1'b1);
        send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'd4, 32'd4, 32'h0040_0213, 1'b0);
        @(negedge clk);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_enc_count", 32'(enc_count), 32'd0);
        chk("midrst_err_seen", 32'(err_seen), 32'd0);
        chk("midrst_out_instr", out_instr, 32'd0);
        chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(5'b11011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd8, 32'h0080_00EF, 1'b0);
        idle(3);
        @(negedge clk);
        chk("final_count", 32'(enc_count), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
